// File: rtl/alu_op_sequencer_if.sv
// Request, ALU operand/result and response signals of the ALU op sequencer.
// Modport master is the sequencer side; slave is the control unit plus ALU side.
interface alu_op_sequencer_if #(
   parameter int unsigned WIDTH = 32
);
   logic             req_valid;
   logic             req_ready;
   logic [3:0]       req_op;
   logic [WIDTH-1:0] req_a;
   logic [WIDTH-1:0] req_b;
   logic [WIDTH-1:0] alu_a;
   logic [WIDTH-1:0] alu_b;
   logic [3:0]       alu_ctrl;
   logic [WIDTH-1:0] alu_c0;
   logic [WIDTH-1:0] alu_c1;
   logic             alu_zero;
   logic             rsp_valid;
   logic             rsp_ready;
   logic [WIDTH-1:0] rsp_lo;
   logic [WIDTH-1:0] rsp_hi;
   logic             rsp_zero;
   logic             rsp_err;

   modport master (
      input  req_valid, req_op, req_a, req_b, alu_c0, alu_c1, alu_zero, rsp_ready,
      output req_ready, alu_a, alu_b, alu_ctrl, rsp_valid, rsp_lo, rsp_hi, rsp_zero, rsp_err
   );

   modport slave (
      output req_valid, req_op, req_a, req_b, alu_c0, alu_c1, alu_zero, rsp_ready,
      input  req_ready, alu_a, alu_b, alu_ctrl, rsp_valid, rsp_lo, rsp_hi, rsp_zero, rsp_err
   );
endinterface

// File: rtl/alu_op_sequencer.sv
// Drives registered operands onto a combinational ALU, waits a settle time, captures the result.
// Optional macro ALU_SEQ_ILLEGAL_OP_TRAP_EN: ops 13-15 return an error response without waiting.
module alu_op_sequencer #(
   parameter int unsigned WIDTH      = 32,
   parameter int unsigned SHORT_WAIT = 0,
   parameter int unsigned LONG_WAIT  = 3
) (
   input logic             clk,
   input logic             rst,
   alu_op_sequencer_if.master bus
);
   typedef enum logic [1:0] {StIdle, StSettle, StResp} state_e;

   localparam logic [7:0] ShortWait = 8'(SHORT_WAIT);
   localparam logic [7:0] LongWait  = 8'(LONG_WAIT);

   state_e           state_q;
   logic [7:0]       cnt_q;
   logic [WIDTH-1:0] alu_a_q;
   logic [WIDTH-1:0] alu_b_q;
   logic [3:0]       alu_ctrl_q;
   logic [WIDTH-1:0] rsp_lo_q;
   logic [WIDTH-1:0] rsp_hi_q;
   logic             rsp_zero_q;
   logic             rsp_valid_q;
   logic             req_ready_q;
`ifdef ALU_SEQ_ILLEGAL_OP_TRAP_EN
   logic             rsp_err_q;
`endif

   logic req_long;
   logic cur_long;
   assign req_long = (bus.req_op == 4'd9) || (bus.req_op == 4'd10);
   assign cur_long = (alu_ctrl_q == 4'd9) || (alu_ctrl_q == 4'd10);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         alu_a_q     <= '0;
         alu_b_q     <= '0;
         alu_ctrl_q  <= '0;
         rsp_lo_q    <= '0;
         rsp_hi_q    <= '0;
         rsp_zero_q  <= 1'b0;
         rsp_valid_q <= 1'b0;
         req_ready_q <= 1'b1;
`ifdef ALU_SEQ_ILLEGAL_OP_TRAP_EN
         rsp_err_q   <= 1'b0;
`endif
      end else begin
         unique case (state_q)
            StIdle: begin
               if (bus.req_valid) begin
                  alu_a_q     <= bus.req_a;
                  alu_b_q     <= bus.req_b;
                  alu_ctrl_q  <= bus.req_op;
                  req_ready_q <= 1'b0;
`ifdef ALU_SEQ_ILLEGAL_OP_TRAP_EN
                  if (bus.req_op >= 4'd13) begin
                     rsp_lo_q    <= '0;
                     rsp_hi_q    <= '0;
                     rsp_zero_q  <= 1'b1;
                     rsp_err_q   <= 1'b1;
                     rsp_valid_q <= 1'b1;
                     state_q     <= StResp;
                  end else
`endif
                  begin
                     cnt_q   <= req_long ? LongWait : ShortWait;
                     state_q <= StSettle;
                  end
               end
            end
            StSettle: begin
               if (cnt_q != 8'd0) begin
                  cnt_q <= cnt_q - 8'd1;
               end else begin
                  rsp_lo_q    <= bus.alu_c0;
                  // Only mul/div produce a meaningful high word.
                  rsp_hi_q    <= cur_long ? bus.alu_c1 : '0;
                  rsp_zero_q  <= bus.alu_zero;
                  rsp_valid_q <= 1'b1;
`ifdef ALU_SEQ_ILLEGAL_OP_TRAP_EN
                  rsp_err_q   <= 1'b0;
`endif
                  state_q     <= StResp;
               end
            end
            StResp: begin
               if (bus.rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  req_ready_q <= 1'b1;
                  state_q     <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign bus.req_ready = req_ready_q;
   assign bus.alu_a     = alu_a_q;
   assign bus.alu_b     = alu_b_q;
   assign bus.alu_ctrl  = alu_ctrl_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_lo    = rsp_lo_q;
   assign bus.rsp_hi    = rsp_hi_q;
   assign bus.rsp_zero  = rsp_zero_q;
`ifdef ALU_SEQ_ILLEGAL_OP_TRAP_EN
   assign bus.rsp_err   = rsp_err_q;
`else
   assign bus.rsp_err   = 1'b0;
`endif
endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural ALU and an expected-response queue.
module tb_alu_op_sequencer;
   localparam int unsigned W = 32;

   typedef struct {
      logic [W-1:0] lo;
      logic [W-1:0] hi;
      logic         zero;
      logic         err;
      int           lat;
   } exp_t;

   logic clk;
   logic rst;
   int   checks;
   int   errors;
   exp_t sb[$];

   alu_op_sequencer_if #(.WIDTH(W)) bus ();

   alu_op_sequencer #(
      .WIDTH     (W),
      .SHORT_WAIT(0),
      .LONG_WAIT (3)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [2*W-1:0] alu_model(logic [3:0] op, logic [W-1:0] a, logic [W-1:0] b);
      logic [2*W-1:0] r;
      logic [4:0]     s;
      s = b[4:0];
      r = '0;
      case (op)
         4'd0:  r[W-1:0] = a + b;
         4'd1:  r[W-1:0] = a - b;
         4'd2:  r[W-1:0] = a & b;
         4'd3:  r[W-1:0] = a | b;
         4'd4:  r[W-1:0] = (a >> s) | (a << (6'd32 - {1'b0, s}));
         4'd5:  r[W-1:0] = (a << s) | (a >> (6'd32 - {1'b0, s}));
         4'd6:  r[W-1:0] = a >> s;
         4'd7:  r[W-1:0] = $unsigned($signed(a) >>> s);
         4'd8:  r[W-1:0] = a << s;
         4'd9:  r = (b == 0) ? {a, {W{1'b1}}} : {a % b, a / b};
         4'd10: r = {{W{1'b0}}, a} * {{W{1'b0}}, b};
         4'd11: r[W-1:0] = -a;
         4'd12: r[W-1:0] = ~a;
         default: r = '0;
      endcase
      return r;
   endfunction

   logic [2*W-1:0] alu_out;
   assign alu_out      = alu_model(bus.alu_ctrl, bus.alu_a, bus.alu_b);
   assign bus.alu_c0   = alu_out[W-1:0];
   assign bus.alu_c1   = alu_out[2*W-1:W];
   assign bus.alu_zero = (alu_out[W-1:0] == '0);

   task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic exp_t expect_for(logic [3:0] op, logic [W-1:0] a, logic [W-1:0] b);
      exp_t           e;
      logic [2*W-1:0] r;
      logic           lng;
      r     = alu_model(op, a, b);
      lng   = (op == 4'd9) || (op == 4'd10);
      e.lo  = r[W-1:0];
      e.hi  = lng ? r[2*W-1:W] : '0;
      e.zero = (r[W-1:0] == '0);
      e.err = 1'b0;
      e.lat = lng ? 4 : 1;
`ifdef ALU_SEQ_ILLEGAL_OP_TRAP_EN
      if (op >= 4'd13) begin
         e.lo = '0; e.hi = '0; e.zero = 1'b1; e.err = 1'b1; e.lat = 1;
      end
`endif
      return e;
   endfunction

   // Returns #1 after the accept edge with the expected response queued.
   task automatic send(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      bit ok;
      ok = 0;
      bus.req_op = op; bus.req_a = a; bus.req_b = b; bus.req_valid = 1'b1;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(negedge clk);
         if (bus.req_ready) ok = 1;
         @(posedge clk);
         #1;
      end
      bus.req_valid = 1'b0;
      checks++;
      assert (ok) else begin
         errors++;
         $error("FAIL accept_timeout observed=0 expected=1");
      end
      sb.push_back(expect_for(op, a, b));
   endtask

   task automatic wait_rsp(input string tag);
      int   n;
      exp_t e;
      n = 0;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk);
         #1;
         if (bus.rsp_valid) begin
            n = i;
            break;
         end
      end
      e = sb.pop_front();
      check({tag, "_latency"}, W'(n), W'(e.lat));
      check({tag, "_lo"}, bus.rsp_lo, e.lo);
      check({tag, "_hi"}, bus.rsp_hi, e.hi);
      check({tag, "_zero"}, W'(bus.rsp_zero), W'(e.zero));
      check({tag, "_err"}, W'(bus.rsp_err), W'(e.err));
   endtask

   task automatic handshake(input string tag);
      bus.rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.rsp_ready = 1'b0;
      check({tag, "_valid_drop"}, W'(bus.rsp_valid), W'(0));
      check({tag, "_ready_rise"}, W'(bus.req_ready), W'(1));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [W-1:0] held_lo;
      checks = 0;
      errors = 0;
      rst = 1'b1;
      bus.req_valid = 1'b0; bus.req_op = '0; bus.req_a = '0; bus.req_b = '0;
      bus.rsp_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      check("rst_req_ready", W'(bus.req_ready), W'(1));
      check("rst_rsp_valid", W'(bus.rsp_valid), W'(0));
      check("rst_alu_a", bus.alu_a, '0);
      check("rst_alu_ctrl", W'(bus.alu_ctrl), W'(0));
      check("rst_rsp_lo", bus.rsp_lo, '0);
      check("rst_rsp_err", W'(bus.rsp_err), W'(0));

      // add with rsp_ready already high before the response
      bus.rsp_ready = 1'b1;
      send(4'd0, 32'd5, 32'd7);
      wait_rsp("add");
      check("add_lo_const", bus.rsp_lo, 32'd12);
      handshake("add");

      // sub to zero, held two cycles in RESP
      send(4'd1, 32'd9, 32'd9);
      wait_rsp("sub");
      check("sub_zero_const", W'(bus.rsp_zero), W'(1));
      repeat (2) @(posedge clk);
      #1;
      check("sub_ctrl_stable", W'(bus.alu_ctrl), W'(1));
      check("sub_valid_held", W'(bus.rsp_valid), W'(1));
      handshake("sub");

      // mul, then backpressure with a pending and request
      send(4'd10, 32'h0001_0000, 32'h0001_0000);
      wait_rsp("mul");
      check("mul_hi_const", bus.rsp_hi, 32'd1);
      held_lo = bus.rsp_lo;
      bus.req_op = 4'd2; bus.req_a = 32'hF0F0_00FF; bus.req_b = 32'h0FF0_F00F;
      bus.req_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         check("bp_req_ready", W'(bus.req_ready), W'(0));
         check("bp_ctrl_kept", W'(bus.alu_ctrl), W'(10));
         check("bp_hi_kept", bus.rsp_hi, 32'd1);
      end
      check("bp_lo_kept", bus.rsp_lo, held_lo);
      handshake("bp");
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      sb.push_back(expect_for(4'd2, 32'hF0F0_00FF, 32'h0FF0_F00F));
      check("bp_accepted_ctrl", W'(bus.alu_ctrl), W'(2));
      check("bp_accepted_ready", W'(bus.req_ready), W'(0));
      wait_rsp("and");
      handshake("and");

      // full div, then a div interrupted by reset in its 2nd settle cycle
      send(4'd9, 32'd100, 32'd7);
      wait_rsp("div");
      handshake("div");
      send(4'd9, 32'd55, 32'd4);
      void'(sb.pop_front());
      @(posedge clk);
      #1;
      rst = 1'b1;
      bus.rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      bus.rsp_ready = 1'b0;
      check("rstmid_rsp_valid", W'(bus.rsp_valid), W'(0));
      check("rstmid_req_ready", W'(bus.req_ready), W'(1));
      check("rstmid_alu_ctrl", W'(bus.alu_ctrl), W'(0));
      check("rstmid_alu_a", bus.alu_a, '0);
      check("rstmid_rsp_lo", bus.rsp_lo, '0);
      repeat (6) @(posedge clk);
      #1;
      check("rstmid_no_rsp", W'(bus.rsp_valid), W'(0));

      // shift ops and a reserved op
      send(4'd7, 32'h8000_0010, 32'd4);
      wait_rsp("shra");
      handshake("shra");
      send(4'd4, 32'h0000_00F1, 32'd4);
      wait_rsp("rotr");
      handshake("rotr");
      send(4'd14, 32'd3, 32'd4);
      wait_rsp("rsvd");
      handshake("rsvd");
      check("end_alu_a_kept", bus.alu_a, 32'd3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
